// File: rtl/fc_engine_param.sv
// Parametrised fully-connected layer engine: PO MAC lanes per group, arithmetic shift + saturate, results on a valid/ready stream.
// Latency: first result group valid INNEURON+2 edges after start is sampled; each further group INNEURON+3 cycles.
// Backpressure: the result group is held stable in OUT until out_ready; no memory reads are issued while waiting.
//
// Ports: clock/reset (async active-low); start/busy/done control; in_neuron_* and fc_weight_*
// are 1-cycle-latency read ports; out_valid/out_ready/out_data/out_group/out_lane_mask form the result stream.
// Optional macro FC_RELU_EN: clamp negative results to 0 after saturation.
module fc_engine_param #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int INNEURON  = 4,
  parameter int OUTNEURON = 6,
  parameter int PO        = 4,
  parameter int SHIFT     = 2,
  parameter int IN_ADDR_W = 2,
  parameter int W_ADDR_W  = 3,
  localparam int NGROUP    = (OUTNEURON + PO - 1) / PO,
  localparam int OUT_IDX_W = (NGROUP > 1) ? $clog2(NGROUP) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [IN_ADDR_W-1:0]   in_neuron_addr,
  output logic                   in_neuron_rden,
  input  logic [DATA_W-1:0]      in_neuron_q,
  output logic [W_ADDR_W-1:0]    fc_weight_addr,
  output logic                   fc_weight_rden,
  input  logic [PO*DATA_W-1:0]   fc_weight_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PO*DATA_W-1:0]   out_data,
  output logic [OUT_IDX_W-1:0]   out_group,
  output logic [PO-1:0]          out_lane_mask
);

  // Accumulator must hold INNEURON full-precision products without wrapping.
  if (ACC_W < 2*DATA_W + $clog2(INNEURON)) begin : g_acc_w_check
    $error("fc_engine_param: ACC_W too small for DATA_W/INNEURON");
  end

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, QUANT, OUT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IN_ADDR_W-1:0]    i_q, i_d;
  logic [OUT_IDX_W-1:0]    group_q, group_d;
  logic                    last_i, last_group;

  // MAC pipeline: read data returns one cycle after the LOAD cycle that requested it.
  logic                    mac_vld_q, mac_first_q;
  logic signed [ACC_W-1:0] acc_q [PO];
  logic signed [2*DATA_W-1:0] prod [PO];
  logic signed [ACC_W-1:0]    prod_ext [PO];

  logic [PO*DATA_W-1:0]    out_data_q, quant_dat;
  logic [OUT_IDX_W-1:0]    out_group_q;
  logic [PO-1:0]           out_mask_q, lane_mask;

  assign last_i     = (i_q == IN_ADDR_W'(INNEURON - 1));
  assign last_group = (group_q == OUT_IDX_W'(NGROUP - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      group_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      group_q <= group_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    group_d = group_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        i_d     = '0;
        group_d = '0;
      end
      LOAD: if (last_i) begin
        state_d = DRAIN;
        i_d     = '0;
      end else begin
        i_d = i_q + IN_ADDR_W'(1);
      end
      DRAIN: state_d = QUANT;
      QUANT: state_d = OUT;
      OUT: if (out_ready) begin
        if (last_group) begin
          state_d = DONE;
        end else begin
          group_d = group_q + OUT_IDX_W'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
        group_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign in_neuron_rden = (state_q == LOAD);
  assign fc_weight_rden = (state_q == LOAD);
  assign in_neuron_addr = (state_q == LOAD) ? i_q : '0;
  assign fc_weight_addr = (state_q == LOAD) ? W_ADDR_W'(int'(group_q) * INNEURON + int'(i_q)) : '0;
  assign out_valid      = (state_q == OUT);
  assign out_data       = out_data_q;
  assign out_group      = out_group_q;
  assign out_lane_mask  = out_mask_q;

  always_comb begin
    for (int j = 0; j < PO; j++) begin
      prod[j]     = $signed(in_neuron_q) * $signed(fc_weight_q[j*DATA_W +: DATA_W]);
      prod_ext[j] = {{(ACC_W-2*DATA_W){prod[j][2*DATA_W-1]}}, prod[j]};
    end
  end

  // Lanes past OUTNEURON in the final group carry no neuron.
  always_comb begin
    for (int j = 0; j < PO; j++) begin
      lane_mask[j] = (int'(group_q) * PO + j) < OUTNEURON;
    end
  end

  always_comb begin : quant_p
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W-1:0]       q;
    quant_dat = '0;
    for (int j = 0; j < PO; j++) begin
      sh = acc_q[j] >>> SHIFT;
      if (sh > SAT_MAX)      q = SAT_MAX[DATA_W-1:0];
      else if (sh < SAT_MIN) q = SAT_MIN[DATA_W-1:0];
      else                   q = sh[DATA_W-1:0];
`ifdef FC_RELU_EN
      if (q[DATA_W-1]) q = '0;
`endif
      if (!lane_mask[j]) q = '0;
      quant_dat[j*DATA_W +: DATA_W] = q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mac_vld_q   <= 1'b0;
      mac_first_q <= 1'b0;
      for (int j = 0; j < PO; j++) acc_q[j] <= '0;
      out_data_q  <= '0;
      out_group_q <= '0;
      out_mask_q  <= '0;
    end else begin
      mac_vld_q   <= (state_q == LOAD);
      mac_first_q <= (i_q == '0);
      if (mac_vld_q) begin
        // First product of a group overwrites, so nothing from a prior group survives.
        for (int j = 0; j < PO; j++) begin
          acc_q[j] <= mac_first_q ? prod_ext[j] : acc_q[j] + prod_ext[j];
        end
      end
      if (state_q == QUANT) begin
        out_data_q  <= quant_dat;
        out_group_q <= group_q;
        out_mask_q  <= lane_mask;
      end
    end
  end

endmodule

// File: tb/tb_fc_engine_param.sv
// Directed bench for fc_engine_param with 1-cycle-latency memory models.
// Latency: n/a.
// Backpressure: out_ready driven per step.
module tb_fc_engine_param;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done;
  logic [1:0]  in_neuron_addr;
  logic        in_neuron_rden;
  logic [7:0]  in_neuron_q;
  logic [2:0]  fc_weight_addr;
  logic        fc_weight_rden;
  logic [31:0] fc_weight_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [0:0]  out_group;
  logic [3:0]  out_lane_mask;

  logic [7:0]  in_mem [4];
  logic [31:0] w_mem  [8];

  int nvec = 0;
  int nerr = 0;

  fc_engine_param dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_neuron_addr(in_neuron_addr), .in_neuron_rden(in_neuron_rden), .in_neuron_q(in_neuron_q),
    .fc_weight_addr(fc_weight_addr), .fc_weight_rden(fc_weight_rden), .fc_weight_q(fc_weight_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_group(out_group), .out_lane_mask(out_lane_mask)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (in_neuron_rden) in_neuron_q <= in_mem[in_neuron_addr];
    if (fc_weight_rden) fc_weight_q <= w_mem[fc_weight_addr];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] ins, input logic [31:0] w0, input logic [31:0] w1);
    for (int k = 0; k < 4; k++) begin
      in_mem[k]  = ins[k*8 +: 8];
      w_mem[k]   = w0;
      w_mem[k+4] = w1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [31:0] exp_neg0, exp_neg1, exp_r0, exp_r1;

  initial begin
`ifdef FC_RELU_EN
    exp_neg0 = 32'h00000000;
    exp_neg1 = 32'h00000000;
    exp_r0   = 32'h0C070002;
    exp_r1   = 32'h0000000A;
`else
    exp_neg0 = 32'h80808080;
    exp_neg1 = 32'h00008080;
    exp_r0   = 32'h0C07FD02;
    exp_r1   = 32'h0000F60A;
`endif
    in_neuron_q = '0;
    fc_weight_q = '0;
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    fill(32'h01010101, 32'h02020202, 32'h02020202);

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", {in_neuron_rden, fc_weight_rden}, 0);
    check("rst_addr", {in_neuron_addr, fc_weight_addr}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out", {out_data, out_group, out_lane_mask}, 0);
    steps(2);
    reset = 1'b1;
    step();

    // Run 1: inputs 1, weights 2
    pulse_start();
    check("r1_busy", busy, 1);
    check("r1_rden", {in_neuron_rden, fc_weight_rden}, 2'b11);
    check("r1_addr0", {in_neuron_addr, fc_weight_addr}, {2'd0, 3'd0});
    steps(2);
    check("r1_addr2", {in_neuron_addr, fc_weight_addr}, {2'd2, 3'd2});
    steps(3);
    check("r1_valid_early", out_valid, 0);
    step();
    check("r1_valid_g0", out_valid, 1);
    check("r1_data_g0", out_data, 32'h02020202);
    check("r1_mask_g0", {out_group, out_lane_mask}, {1'b0, 4'b1111});
    check("r1_norden_out", in_neuron_rden | fc_weight_rden, 0);
    step();
    check("r1_valid_drop", out_valid, 0);
    check("r1_g1_waddr", {fc_weight_rden, fc_weight_addr}, {1'b1, 3'd4});
    steps(6);
    check("r1_valid_g1", out_valid, 1);
    check("r1_data_g1", out_data, 32'h00000202);
    check("r1_mask_g1", {out_group, out_lane_mask}, {1'b1, 4'b0011});
    step();
    check("r1_done", {done, busy}, 2'b11);
    step();
    check("r1_idle", {done, busy}, 2'b00);

    // Run 2: saturate high, with 5 cycles of backpressure on group 0
    fill(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F);
    out_ready = 1'b0;
    pulse_start();
    steps(6);
    check("r2_valid_g0", out_valid, 1);
    check("r2_data_g0", out_data, 32'h7F7F7F7F);
    for (int k = 0; k < 5; k++) begin
      step();
      check("r2_hold", {out_valid, in_neuron_rden, fc_weight_rden, out_data, out_group, out_lane_mask},
            {1'b1, 1'b0, 1'b0, 32'h7F7F7F7F, 1'b0, 4'b1111});
    end
    out_ready = 1'b1;
    step();
    check("r2_g1_load", {out_valid, fc_weight_rden, fc_weight_addr}, {1'b0, 1'b1, 3'd4});
    steps(6);
    check("r2_data_g1", {out_valid, out_data, out_group, out_lane_mask}, {1'b1, 32'h00007F7F, 1'b1, 4'b0011});
    step();
    check("r2_done", done, 1);
    step();

    // Run 3: saturate low, with start pulses while busy
    fill(32'h7F7F7F7F, 32'h80808080, 32'h80808080);
    pulse_start();
    step();
    pulse_start();
    steps(4);
    check("r3_valid_g0", out_valid, 1);
    check("r3_data_g0", out_data, exp_neg0);
    pulse_start();
    check("r3_g1_waddr", {out_valid, fc_weight_rden, fc_weight_addr}, {1'b0, 1'b1, 3'd4});
    steps(6);
    check("r3_data_g1", {out_valid, out_data, out_group, out_lane_mask}, {1'b1, exp_neg1, 1'b1, 4'b0011});
    start = 1'b1;
    step();
    check("r3_done", {done, busy}, 2'b11);
    step();
    start = 1'b0;
    check("r3_idle", {done, busy}, 2'b00);
    step();
    check("r3_no_restart", {busy, in_neuron_rden}, 2'b00);

    // Run 4: reset during LOAD cycle 2, then rerun with new data
    fill(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F);
    pulse_start();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("r4_rst_ctl", {busy, done, in_neuron_rden, fc_weight_rden, out_valid}, 0);
    check("r4_rst_addr", {in_neuron_addr, fc_weight_addr}, 0);
    check("r4_rst_out", {out_data, out_group, out_lane_mask}, 0);
    step();
    reset = 1'b1;
    fill(32'h04030201, 32'h0503FF01, 32'h0707FC04);
    step();
    pulse_start();
    steps(6);
    check("r4_data_g0", {out_valid, out_data, out_group, out_lane_mask}, {1'b1, exp_r0, 1'b0, 4'b1111});
    step();
    steps(6);
    check("r4_data_g1", {out_valid, out_data, out_group, out_lane_mask}, {1'b1, exp_r1, 1'b1, 4'b0011});
    step();
    check("r4_done", {done, busy}, 2'b11);
    step();
    check("r4_idle", {done, busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
